if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/codes_pkg.sv | 4 +
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/codes_pkg.sv
// codes_pkg: shared word width for the fetch path.
package codes_pkg;
    localparam int WORD_WIDTH = 32;
endpackage

// File: rtl/if_stage.sv
// if_stage: credit-limited instruction fetch with an address tag queue and a decode FIFO.
// Defining IF_STAGE_PERF_CNT_EN adds a saturating stall_cnt output.
module if_stage
    import codes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] pc_current,
    input  logic                  flush,
    output logic                  pc_en,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WORD_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [WORD_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    output logic [WORD_WIDTH-1:0] if_instr,
    output logic [WORD_WIDTH-1:0] if_pc,
`ifdef IF_STAGE_PERF_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    input  logic                  id_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_WIDTH-1:0] r_tag [DEPTH];
    logic [WORD_WIDTH-1:0] r_fifo_pc [DEPTH];
    logic [WORD_WIDTH-1:0] r_fifo_instr [DEPTH];
    logic [AW-1:0] r_tag_wr, r_tag_rd, r_fifo_wr, r_fifo_rd;
    logic [AW:0] r_outstanding, r_drop_cnt, r_fifo_count, w_out_less_rsp;
    logic [AW+1:0] w_used;
    logic w_accept, w_rsp_keep, w_pop, w_fifo_empty;

    // Outstanding includes responses still to be dropped, so credits cover them too.
    assign w_used = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_out_less_rsp = r_outstanding - (AW+1)'(imem_rsp_valid);
    assign w_fifo_empty = r_fifo_count == '0;
    assign imem_req_addr = pc_current;
    assign imem_req_valid = !rst && !flush && (w_used < (AW+2)'(DEPTH));
    assign w_accept = imem_req_valid && imem_req_ready;
    assign pc_en = !rst && (w_accept || flush);
    assign w_rsp_keep = imem_rsp_valid && !flush && r_drop_cnt == '0;
    assign if_valid = !rst && !flush && !w_fifo_empty;
    assign w_pop = if_valid && id_ready;
    assign if_instr = w_fifo_empty ? '0 : r_fifo_instr[r_fifo_rd];
    assign if_pc = w_fifo_empty ? '0 : r_fifo_pc[r_fifo_rd];

    always_ff @(posedge clk) begin
        if (w_accept)
            r_tag[r_tag_wr] <= pc_current;
        if (w_rsp_keep) begin
            r_fifo_pc[r_fifo_wr] <= r_tag[r_tag_rd];
            r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            r_fifo_wr <= '0;
            r_fifo_rd <= '0;
            r_fifo_count <= '0;
        end else begin
            r_tag_wr <= r_tag_wr + AW'(w_accept);
            r_tag_rd <= r_tag_rd + AW'(w_rsp_keep);
            r_fifo_wr <= r_fifo_wr + AW'(w_rsp_keep);
            r_fifo_rd <= r_fifo_rd + AW'(w_pop);
            r_fifo_count <= r_fifo_count + (AW+1)'(w_rsp_keep) - (AW+1)'(w_pop);
        end
    end

    // A flush leaves every older in-flight response marked for discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_outstanding <= w_out_less_rsp;
            r_drop_cnt <= w_out_less_rsp;
        end else begin
            r_outstanding <= w_out_less_rsp + (AW+1)'(w_accept);
            r_drop_cnt <= r_drop_cnt - (AW+1)'(imem_rsp_valid && r_drop_cnt != '0);
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (!imem_req_valid && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage against a transaction-level fetch model.
// Set IF_STAGE_PERF_CNT_EN to also check stall_cnt.
module tb_if_stage;
    import codes_pkg::*;
    localparam int DEPTH = 2;
    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef struct {
        word_t addr;
        int    due;
        bit    live;
    } mreq_t;

    logic clk = 1'b0;
    logic rst, flush, pc_en, imem_req_valid, imem_req_ready, imem_rsp_valid, if_valid, id_ready;
    word_t pc_current, imem_req_addr, imem_rsp_data, if_instr, if_pc, tgt;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    int unsigned stall_m;
`endif

    mreq_t mem_q[$];
    word_t exp_q[$];
    int n_del, cyc, total, bad, lat_lo, lat_hi, rsp_pct;
    bit s_rst = 1'b1, s_pc_en, s_flush;
    word_t s_tgt;

    if_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_current(pc_current), .flush(flush), .pc_en(pc_en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
`ifdef IF_STAGE_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    function automatic word_t mem_word(input word_t a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Monitor and scoreboard: the model follows the fetch rules on whole transactions.
    initial begin
        bit erv, eacc;
        mreq_t m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_req_valid", imem_req_valid, 0);
                chk("rst_pc_en", pc_en, 0);
                chk("rst_if_valid", if_valid, 0);
                mem_q.delete();
                exp_q.delete();
                n_del = 0;
                s_pc_en = 0;
`ifdef IF_STAGE_PERF_CNT_EN
                stall_m = 0;
`endif
            end else begin
                erv = !flush && (mem_q.size() + n_del < DEPTH);
                eacc = erv && imem_req_ready;
                chk("req_valid", imem_req_valid, erv);
                chk("pc_en", pc_en, eacc || flush);
                chk("req_addr", imem_req_addr, pc_current);
                chk("if_valid", if_valid, !flush && n_del > 0);
`ifdef IF_STAGE_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, stall_m);
                if (!erv && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
                if (n_del == 0) begin
                    chk("empty_pc", if_pc, 0);
                    chk("empty_instr", if_instr, 0);
                end
                if (!flush && n_del > 0 && id_ready) begin
                    chk("if_pc", if_pc, exp_q[0]);
                    chk("if_instr", if_instr, mem_word(exp_q[0]));
                    void'(exp_q.pop_front());
                    n_del--;
                end
                if (imem_rsp_valid && mem_q.size() > 0) begin
                    m = mem_q.pop_front();
                    if (!flush && m.live) n_del++;
                end
                if (flush) begin
                    foreach (mem_q[i]) mem_q[i].live = 0;
                    exp_q.delete();
                    n_del = 0;
                end
                if (eacc) begin
                    m.addr = pc_current;
                    m.due = cyc + int'($urandom_range(lat_hi, lat_lo));
                    m.live = 1;
                    mem_q.push_back(m);
                    exp_q.push_back(pc_current);
                end
                s_pc_en = eacc || flush;
            end
            s_rst = rst;
            s_flush = flush;
            s_tgt = tgt;
        end
    end

    // Driver: acts as the PC register and an in-order memory with variable latency.
    task automatic step(input bit r, input bit f, input word_t t, input bit rdy, input bit idr);
        @(posedge clk);
        #1;
        if (s_rst) pc_current = '0;
        else if (s_pc_en) pc_current = s_flush ? s_tgt : pc_current + 32'd4;
        rst = r;
        flush = f;
        tgt = t;
        imem_req_ready = rdy;
        id_ready = idr;
        imem_rsp_valid = 0;
        imem_rsp_data = $urandom;
        if (!r && mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc + 1 && $urandom_range(99) < rsp_pct) begin
                imem_rsp_valid = 1;
                imem_rsp_data = mem_word(mem_q[0].addr);
            end
        end
    endtask

    task automatic reset_lat(input int lo, input int hi);
        lat_lo = lo;
        lat_hi = hi;
        repeat (2) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; tgt = 0; imem_req_ready = 0; id_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; pc_current = 0; rsp_pct = 100;
        reset_lat(1, 1);
        repeat (20) step(0, 0, 0, 1, 1);
        reset_lat(1, 1);
        repeat (8) step(0, 0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 1, 1);
        reset_lat(3, 3);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 1, 32'h100, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);
        reset_lat(2, 2);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 1, 32'h200, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);
        reset_lat(2, 2);
        repeat (3) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 1, 1);
        reset_lat(20, 20);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (25) step(0, 0, 0, 1, 1);
        rsp_pct = 80;
        for (int blk = 0; blk < 6; blk++) begin
            lat_lo = 1;
            lat_hi = 1 + blk % 4;
            for (int k = 0; k < 250; k++)
                step($urandom_range(199) == 0, $urandom_range(19) == 0, word_t'($urandom) & ~word_t'(3),
                     $urandom_range(99) < 70, $urandom_range(99) < 60);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
